// File: rtl/ysyx_220053_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_pkg
// Purpose : Shared constants for the ysyx_220053 core front end.
//           XLEN / ILEN give the default PC and instruction widths.
//           RESET_PC is the architectural reset vector.
//           NOP_INSTR is the canonical RISC-V NOP (addi x0, x0, 0).
// Revision: 1.0 - initial release
// ============================================================================
package ysyx_220053_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Width of an occupancy counter able to hold the values 0..depth.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : ysyx_220053_pkg
`default_nettype wire

// File: rtl/ysyx_220053_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_fifo_ctrl
// Purpose : Pointer and occupancy bookkeeping for a circular buffer of DEPTH
//           entries (DEPTH a power of two, so pointers wrap naturally).
// Ports   : clk, rst (async, active-low)
//           push   - a write is committed on this edge (caller gates with !full)
//           pop    - a read is committed on this edge (caller gates with !empty)
//           flush  - clears pointers and count; wins over push/pop
//           rd_ptr, wr_ptr - slot indices of the head / next free slot
//           count  - number of buffered entries
//           full, empty - decoded from count
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_220053_fifo_ctrl
  import ysyx_220053_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic                          flush,
  output logic [$clog2(DEPTH)-1:0]      rd_ptr,
  output logic [$clog2(DEPTH)-1:0]      wr_ptr,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = count_width(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CNT_DEPTH);
  assign empty = (count == '0);

endmodule : ysyx_220053_fifo_ctrl
`default_nettype wire

// File: rtl/ysyx_220053_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_220053_fetch_queue
// Purpose : In-order decoupling queue between instruction fetch and decode.
//           Buffers up to DEPTH (pc, instr) pairs; flush discards everything.
// Ports   : clk, rst (async, active-low)
//           in_valid / in_ready / in_pc / in_instr    - fetch side handshake
//           out_valid / out_ready / out_pc / out_instr - decode side handshake
//           flush - redirect, drop all buffered entries
//           count - current occupancy
// All outputs depend on registered state only; there is no bypass from the
// input to the output and no path from out_ready to in_ready.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_220053_fetch_queue
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = ysyx_220053_pkg::XLEN,
  parameter int ILEN  = ysyx_220053_pkg::ILEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [ILEN-1:0] NOP_WORD = ILEN'(ysyx_220053_pkg::NOP_INSTR);

  logic [XLEN-1:0]  pc_mem    [DEPTH];
  logic [ILEN-1:0]  instr_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  ysyx_220053_fifo_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk    (clk),
    .rst    (rst),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .count  (count),
    .full   (full),
    .empty  (empty)
  );

  // Data slots carry no reset: a slot is only ever read after it has been
  // written, because the head is masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

  // An empty queue presents a harmless NOP at PC 0 so decode never sees
  // stale slot contents.
  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP_WORD;

endmodule : ysyx_220053_fetch_queue
`default_nettype wire
